// File: rtl/axi_pim_master.sv
// AXI4 burst master: one read or write burst in flight, fed by cmd/stream ports.
// Optional beat counters are built when AXI_PIM_MASTER_PERF_EN is defined.
module axi_pim_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,

  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,

  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,

  output logic                  done,
  output logic [1:0]            done_resp,
  output logic                  busy,

  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,

  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,

  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,

  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,

  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,

  output logic [15:0]           perf_wr_beats,
  output logic [15:0]           perf_rd_beats
);

  localparam logic [ID_WIDTH-1:0] L_ID   = ID_WIDTH'(AXI_ID);
  localparam logic [2:0]          L_SIZE = 3'($clog2(STRB_WIDTH));

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [1:0]            r_rresp_max;
  logic                  r_done;
  logic [1:0]            r_done_resp;

  logic                  w_cmd_hs;
  logic                  w_w_hs;
  logic                  w_r_hs;
  logic                  w_last_beat;
  logic [1:0]            w_rresp_max;
  logic                  w_unused;

  // Slave IDs and rlast are not needed: termination uses our own count.
  assign w_unused = ^{m_axi_bid, m_axi_rid, m_axi_rlast};

  assign w_last_beat = (r_cnt == r_len);
  assign w_cmd_hs    = (r_state == S_IDLE) && cmd_valid;
  assign w_w_hs      = (r_state == S_W) && wr_valid && m_axi_wready;
  assign w_r_hs      = (r_state == S_R) && m_axi_rvalid && rd_ready;
  assign w_rresp_max = (m_axi_rresp > r_rresp_max) ? m_axi_rresp
                                                   : r_rresp_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_next = cmd_write ? S_AW : S_AR;
        end
      end
      S_AW: begin
        if (m_axi_awready) begin
          w_next = S_W;
        end
      end
      S_W: begin
        if (w_w_hs && w_last_beat) begin
          w_next = S_B;
        end
      end
      S_B: begin
        if (m_axi_bvalid) begin
          w_next = S_IDLE;
        end
      end
      S_AR: begin
        if (m_axi_arready) begin
          w_next = S_R;
        end
      end
      S_R: begin
        if (w_r_hs && w_last_beat) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_rresp_max <= '0;
      r_done      <= 1'b0;
      r_done_resp <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_cmd_hs) begin
        r_addr      <= cmd_addr;
        r_len       <= cmd_len;
        r_cnt       <= '0;
        r_rresp_max <= '0;
      end
      if (w_w_hs) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_r_hs) begin
        r_cnt       <= r_cnt + 8'd1;
        r_rresp_max <= w_rresp_max;
        if (w_last_beat) begin
          r_done      <= 1'b1;
          r_done_resp <= w_rresp_max;
        end
      end
      if ((r_state == S_B) && m_axi_bvalid) begin
        r_done      <= 1'b1;
        r_done_resp <= m_axi_bresp;
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign done_resp = r_done_resp;

  assign m_axi_awid    = L_ID;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = r_len;
  assign m_axi_awsize  = L_SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awvalid = (r_state == S_AW);

  assign m_axi_wdata  = wr_data;
  assign m_axi_wstrb  = '1;
  assign m_axi_wlast  = (r_state == S_W) && w_last_beat;
  assign m_axi_wvalid = (r_state == S_W) && wr_valid;
  assign wr_ready     = (r_state == S_W) && m_axi_wready;

  assign m_axi_bready = (r_state == S_B);

  assign m_axi_arid    = L_ID;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = r_len;
  assign m_axi_arsize  = L_SIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arvalid = (r_state == S_AR);

  assign m_axi_rready = (r_state == S_R) && rd_ready;
  assign rd_valid     = (r_state == S_R) && m_axi_rvalid;
  assign rd_data      = m_axi_rdata;
  assign rd_last      = (r_state == S_R) && w_last_beat;

`ifdef AXI_PIM_MASTER_PERF_EN
  logic [15:0] r_perf_wr;
  logic [15:0] r_perf_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_wr <= '0;
      r_perf_rd <= '0;
    end else begin
      if (w_w_hs && (r_perf_wr != 16'hFFFF)) begin
        r_perf_wr <= r_perf_wr + 16'd1;
      end
      if (w_r_hs && (r_perf_rd != 16'hFFFF)) begin
        r_perf_rd <= r_perf_rd + 16'd1;
      end
    end
  end

  assign perf_wr_beats = r_perf_wr;
  assign perf_rd_beats = r_perf_rd;
`else
  assign perf_wr_beats = 16'd0;
  assign perf_rd_beats = 16'd0;
`endif

endmodule

// File: tb/tb_axi_pim_master.sv
// Directed bench for axi_pim_master: slave side driven step by step,
// outputs sampled on the falling edge with hand-computed expectations.
module tb_axi_pim_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;
  logic        done;
  logic [1:0]  done_resp;
  logic        busy;
  logic [7:0]  awid;
  logic [7:0]  awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  arid;
  logic [7:0]  araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [7:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [15:0] perf_wr;
  logic [15:0] perf_rd;

  int n_total = 0;
  int n_pass  = 0;

  axi_pim_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_last(rd_last),
    .done(done), .done_resp(done_resp), .busy(busy),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst),
    .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst),
    .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .perf_wr_beats(perf_wr), .perf_rd_beats(perf_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic issue(input logic w, input logic [7:0] a,
                       input logic [7:0] l);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    #1;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
  endtask

  // Full write burst with an always-ready slave.
  task automatic wr_burst(input logic [7:0] a, input logic [7:0] l,
                          input logic [1:0] resp);
    awready = 1'b1;
    wready  = 1'b1;
    issue(1'b1, a, l);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("awvalid", 32'(awvalid), 32'd1);
    chk("awaddr", 32'(awaddr), 32'(a));
    chk("awlen", 32'(awlen), 32'(l));
    chk("awsize", 32'(awsize), 32'd2);
    chk("awburst", 32'(awburst), 32'd1);
    chk("busy_aw", 32'(busy), 32'd1);
    for (int i = 0; i <= int'(l); i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = 32'(i + 1);
      #1;
      chk("wvalid", 32'(wvalid), 32'd1);
      chk("wdata", wdata, 32'(i + 1));
      chk("wstrb", 32'(wstrb), 32'hF);
      chk("wlast", 32'(wlast), (i == int'(l)) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    bvalid   = 1'b1;
    bresp    = resp;
    #1;
    chk("bready", 32'(bready), 32'd1);
    chk("wvalid_b", 32'(wvalid), 32'd0);
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_done_resp", 32'(done_resp), 32'(resp));
    chk("cmd_ready_done", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_data   = '0;
    wr_valid  = 1'b0;
    rd_ready  = 1'b0;
    awready   = 1'b1;
    wready    = 1'b1;
    bid       = '0;
    bresp     = '0;
    bvalid    = 1'b0;
    arready   = 1'b1;
    rid       = '0;
    rdata     = '0;
    rresp     = '0;
    rlast     = 1'b0;
    rvalid    = 1'b0;

    // reset state
    #12;
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_resp", 32'(done_resp), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rel_perf_wr", 32'(perf_wr), 32'd0);

    // write 0x10 len 3
    wr_burst(8'h10, 8'd3, 2'b00);
    @(negedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);

    // read 0x20 len 0
    issue(1'b0, 8'h20, 8'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("arvalid", 32'(arvalid), 32'd1);
    chk("araddr", 32'(araddr), 32'h20);
    chk("arlen", 32'(arlen), 32'd0);
    chk("arsize", 32'(arsize), 32'd2);
    chk("arburst", 32'(arburst), 32'd1);
    @(negedge clk);
    rvalid   = 1'b1;
    rdata    = 32'hA5;
    rresp    = 2'b00;
    rd_ready = 1'b1;
    #1;
    chk("rd_valid", 32'(rd_valid), 32'd1);
    chk("rd_data", rd_data, 32'hA5);
    chk("rd_last_len0", 32'(rd_last), 32'd1);
    chk("rready", 32'(rready), 32'd1);
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    chk("rd_done", 32'(done), 32'd1);
    chk("rd_done_resp", 32'(done_resp), 32'd0);
    chk("rd_busy_after", 32'(busy), 32'd0);

    // awready stalled 5 cycles; a read is offered meanwhile
    awready = 1'b0;
    issue(1'b1, 8'h30, 8'd0);
    @(negedge clk);
    cmd_write = 1'b0;
    cmd_addr  = 8'h40;
    cmd_len   = 8'd0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("stall_awvalid", 32'(awvalid), 32'd1);
      chk("stall_awaddr", 32'(awaddr), 32'h30);
      chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    awready = 1'b1;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 32'h77;
    #1;
    chk("stall_wlast", 32'(wlast), 32'd1);
    chk("stall_wdata", wdata, 32'h77);
    @(negedge clk);
    wr_valid = 1'b0;
    bvalid   = 1'b1;
    bresp    = 2'b01;
    @(negedge clk);
    bvalid = 1'b0;
    #1;
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_done_resp", 32'(done_resp), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("held_arvalid", 32'(arvalid), 32'd1);
    chk("held_araddr", 32'(araddr), 32'h40);
    @(negedge clk);
    rvalid = 1'b1;
    rdata  = 32'h55;
    rresp  = 2'b00;
    #1;
    chk("held_rd_last", 32'(rd_last), 32'd1);
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    chk("held_done", 32'(done), 32'd1);
    chk("held_done_resp", 32'(done_resp), 32'd0);

    // read len 2, rd_ready toggling, one SLVERR
    issue(1'b0, 8'h20, 8'd2);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("r3_arlen", 32'(arlen), 32'd2);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      rvalid   = 1'b1;
      rdata    = 32'h100 + 32'(b);
      rresp    = (b == 1) ? 2'b10 : 2'b00;
      rd_ready = 1'b0;
      #1;
      chk("r3_rready_low", 32'(rready), 32'd0);
      chk("r3_rd_valid", 32'(rd_valid), 32'd1);
      @(negedge clk);
      rd_ready = 1'b1;
      #1;
      chk("r3_rd_data", rd_data, 32'h100 + 32'(b));
      chk("r3_rd_last", 32'(rd_last), (b == 2) ? 32'd1 : 32'd0);
      chk("r3_done_early", 32'(done), 32'd0);
    end
    @(negedge clk);
    rvalid = 1'b0;
    #1;
    chk("r3_done", 32'(done), 32'd1);
    chk("r3_done_resp", 32'(done_resp), 32'd2);

    // reset during second write beat
    issue(1'b1, 8'h60, 8'd3);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 32'h1;
    @(negedge clk);
    wr_data = 32'h2;
    #1;
    chk("mid_wvalid_pre", 32'(wvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_wvalid", 32'(wvalid), 32'd0);
    chk("mid_wr_ready", 32'(wr_ready), 32'd0);
    chk("mid_awvalid", 32'(awvalid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_perf_wr", 32'(perf_wr), 32'd0);
    @(negedge clk);
    wr_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_no_done", 32'(done), 32'd0);
    chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    wr_burst(8'h70, 8'd1, 2'b00);

    // perf: three writes of 4 beats after a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_burst(8'h80 + 8'(k * 16), 8'd3, 2'b00);
    end
    @(negedge clk);
    #1;
`ifdef AXI_PIM_MASTER_PERF_EN
    chk("perf_wr_beats", 32'(perf_wr), 32'd12);
`else
    chk("perf_wr_beats", 32'(perf_wr), 32'd0);
`endif
    chk("perf_rd_beats", 32'(perf_rd), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
